// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame constants for the SPI master controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE,
    GAP
  } state_t;

  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SPI clock generator: toggles sclk every CLK_DIV enabled cycles, idles low.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_strobe,
  output logic fall_strobe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap        = en && (cnt == CNT_LAST);
  assign rise_strobe = wrap && !sclk;
  assign fall_strobe = wrap && sclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI master: {addr, rw} command then one data byte, MSB first.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(CLK_DIV - 2);

  state_t                  state;
  logic [3:0]              bit_cnt;
  logic [TW-1:0]           tick;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   frame;
  logic [DATA_BITS-1:0]    wdata_eff;
  logic [DATA_BITS-1:0]    rx;
  logic                    rw_q;
  logic                    tail;
  logic                    en;
  logic                    rise;
  logic                    fall;

  assign wdata_eff = (req_rw == RW_READ) ? '0 : req_wdata;
  assign frame     = {req_addr, req_rw, wdata_eff};

  // Low half of the last bit is timed locally so the generator never raises sclk again.
  assign tail = (bit_cnt == 4'd15) && !sclk;
  assign en   = (state == SETUP) || ((state == SHIFT) && !tail);

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sclk        (sclk),
    .rise_strobe (rise),
    .fall_strobe (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs        <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      bit_cnt   <= '0;
      tick      <= '0;
      shreg     <= '0;
      rx        <= '0;
      rw_q      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            rw_q      <= req_rw;
            mosi      <= frame[FRAME_BITS-1];
            shreg     <= {frame[FRAME_BITS-2:0], 1'b0};
            cs        <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            bit_cnt   <= '0;
            tick      <= '0;
            rx        <= '0;
          end
        end
        SETUP: begin
          if (rise) state <= SHIFT;
        end
        SHIFT: begin
          if (tail) begin
            if (tick == TICK_LAST) begin
              state <= HOLD;
              tick  <= '0;
            end else begin
              tick <= tick + 1'b1;
            end
          end else begin
            if (fall) begin
              mosi  <= shreg[FRAME_BITS-1];
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
            // The rise ending period n starts bit n+1, so data bits arrive from bit_cnt 7 on.
            if (rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt >= 4'(CMD_BITS - 1)) rx <= {rx[DATA_BITS-2:0], miso};
            end
          end
        end
        HOLD: begin
          if (tick == TICK_LAST) begin
            state     <= DONE;
            tick      <= '0;
            cs        <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= (rw_q == RW_WRITE) ? '0 : rx;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DONE: begin
          state <= GAP;
        end
        GAP: begin
          if (tick == GAP_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
